adc_frame_gearbox: RTL and testbench
====================================

// Module: adc_frame_gearbox
// PURPOSE
//  Multi-channel serial-ADC deserialiser gearbox. Sits after the per-lane ISERDES (SER_W bits/clk, dco_div4 domain).
//  Converts SER_W-bit lane words into SAMPLE_W-bit samples for NUM_CH channels, framed by the shared FCO lane.
//  FCO frame pattern is SAMPLE_W/2 ones then SAMPLE_W/2 zeros, MSB first.
//  Frame alignment is acquired once by an FSM (SEARCH/VERIFY/LOCKED), then tracked by a phase accumulator.
//  Frame errors are counted; persistent loss drops lock and the FSM re-searches automatically.
// PARAMETERS
//  NUM_CH     4   data lanes (channels) sharing one FCO
//  SER_W      8   bits per lane word per clk; SAMPLE_W >= SER_W required
//  SAMPLE_W   12  sample width, even
//  LOCK_COUNT 4   consecutive good predicted frames in VERIFY needed to enter LOCKED
//  ERR_LIMIT  2   consecutive bad predicted frames in LOCKED that force SEARCH
// PORTS
//  dco_div4       in   1                 word clock
//  rstn           in   1                 async active-low reset
//  fco_word       in   SER_W             FCO lane word, bit SER_W-1 oldest
//  data_in        in   NUM_CH*SER_W      lane words; ch c at [c*SER_W +: SER_W], MSB oldest
//  realign        in   1                 sync pulse: force SEARCH, clear err_cnt
//  data_out       out  NUM_CH*SAMPLE_W   samples; ch c at [c*SAMPLE_W +: SAMPLE_W]
//  data_valid_out out  1                 1-cycle strobe, all channels valid together
//  locked         out  1                 FSM in LOCKED
//  offset         out  $clog2(SER_W)     bit offset of the last emitted frame
//  err_cnt        out  16                saturating count of bad frames seen while LOCKED
// BEHAVIOUR
//  Reset (async): all outputs 0, FSM=SEARCH, shift regs 0, d=0, counters 0.
//  Shift regs: each clk fco_sr <= {fco_sr, fco_word}, data_sr[c] <= {data_sr[c], data_in[c]}.
//   Shift-reg width is SAMPLE_W+SER_W.
//  Candidate frame at offset k: fco_sr[k+SAMPLE_W-1:k] == {SAMPLE_W/2{1},SAMPLE_W/2{0}}, k in 0..SER_W-1.
//   Sample = data_sr[c][k+SAMPLE_W-1:k].
//  Phase accumulator d: each clk d += SER_W. If d >= SAMPLE_W, a frame is expected at k=d-SAMPLE_W,
//   and d is reduced by SAMPLE_W.
//  SEARCH: scan all k. On the lowest-k match, load d=k and go to VERIFY with good=0. No valid out.
//  VERIFY: at each expected frame, check the pattern at the predicted k.
//   - Pass: good++. When good==LOCK_COUNT, go to LOCKED.
//   - Fail: go to SEARCH.
//   - No valid out in VERIFY.
//  LOCKED: at each expected frame, on pass: register the samples and offset=k, pulse data_valid_out, clear bad.
//   - Fail: suppress valid, bad++, err_cnt++ (saturates at 16'hFFFF).
//   - When bad==ERR_LIMIT, go to SEARCH and deassert locked.
//  Latency: data_valid_out and data_out update on the clk edge after the frame is present in the shift regs.
//   This is one registered stage.
//  data_out holds its last value while valid is low. Non-expected cycles never produce valid.
//  Throughput: at most one sample per channel per clk. For 12/8 that is 2 valids per 3 clks.
//  realign: wins over every other event in the same cycle. Next state SEARCH, locked=0 next clk, err_cnt=0,
//   d/good/bad cleared. In-flight valid is suppressed.
//  Reset mid-frame: everything clears immediately. Reacquisition restarts from SEARCH.
// TESTING
//  1 rstn low mid-stream -> all outputs 0 at once. After release, locked=0 until LOCK_COUNT+1 frames have been seen.
//  2 12/8 ramp, frame start offset 3 -> locked after 5 frames. Then data_out = ramp in order on all 4 channels.
//    data_valid_out cadence is 2 of every 3 clks. offset alternates 3 / 7 (k, k+4 mod 8).
//  3 Per-channel distinct ramps (ch c = c*0x100+n) -> no lane swap. Samples are correct MSB-first.
//  4 While locked, corrupt 1 FCO frame -> that valid is missing, err_cnt=1, locked stays 1.
//    Corrupt 2 consecutive frames -> locked=0, relock after 5 clean frames.
//  5 Slip FCO+data by 1 bit while locked -> errors, then SEARCH, then relock with the new offset.
//    No valid is ever emitted with a wrong sample.
//  6 realign pulse coinciding with an expected frame -> no valid that cycle, err_cnt=0, locked=0 next clk.
//    Relock follows normally.

Source files
------------

// File: rtl/adc_frame_gearbox.sv
// rtl/adc_frame_gearbox.sv - multi-lane serial-ADC gearbox: FCO frame lock, phase tracking, sample extraction
module adc_frame_gearbox #(
  parameter int NUM_CH     = 4,
  parameter int SER_W      = 8,
  parameter int SAMPLE_W   = 12,
  parameter int LOCK_COUNT = 4,
  parameter int ERR_LIMIT  = 2
) (
  input  logic                         dco_div4,
  input  logic                         rstn,
  input  logic [SER_W-1:0]             fco_word,
  input  logic [NUM_CH*SER_W-1:0]      data_in,
  input  logic                         realign,
  output logic [NUM_CH*SAMPLE_W-1:0]   data_out,
  output logic                         data_valid_out,
  output logic                         locked,
  output logic [$clog2(SER_W)-1:0]     offset,
  output logic [15:0]                  err_cnt
);

  localparam int SR_W   = SAMPLE_W + SER_W;
  localparam int OFF_W  = $clog2(SER_W);
  localparam int D_W    = $clog2(SR_W);
  localparam int GOOD_W = $clog2(LOCK_COUNT + 1);
  localparam int BAD_W  = $clog2(ERR_LIMIT + 1);

  localparam logic [SAMPLE_W-1:0] FRAME_PAT = {{(SAMPLE_W/2){1'b1}}, {(SAMPLE_W/2){1'b0}}};
  localparam logic [D_W-1:0]      SER_D     = D_W'(SER_W);
  localparam logic [D_W-1:0]      SAMPLE_D  = D_W'(SAMPLE_W);
  localparam logic [GOOD_W-1:0]   GOOD_LAST = GOOD_W'(LOCK_COUNT - 1);
  localparam logic [BAD_W-1:0]    BAD_LAST  = BAD_W'(ERR_LIMIT - 1);

  typedef enum logic [1:0] {
    ST_SEARCH,
    ST_VERIFY,
    ST_LOCKED
  } state_t;

  state_t                      state;
  logic [SR_W-1:0]             fco_sr;
  logic [SR_W-1:0]             data_sr [NUM_CH];
  logic [D_W-1:0]              d;
  logic [GOOD_W-1:0]           good;
  logic [BAD_W-1:0]            bad;

  logic [SER_W-1:0]            match_vec;
  logic                        search_hit;
  logic [OFF_W-1:0]            search_k;
  logic [D_W-1:0]              d_sum;
  logic [D_W-1:0]              d_red;
  logic [D_W-1:0]              d_next;
  logic                        frame_due;
  logic [OFF_W-1:0]            pred_k;
  logic                        pred_ok;
  logic [NUM_CH*SAMPLE_W-1:0]  pred_data;

  // One comparator per candidate offset; shared by the search scan and the predicted check.
  always_comb begin
    match_vec = '0;
    for (int k = 0; k < SER_W; k++) begin
      match_vec[k] = (fco_sr[k +: SAMPLE_W] == FRAME_PAT);
    end
  end

  always_comb begin
    search_hit = |match_vec;
    search_k   = '0;
    for (int k = SER_W - 1; k >= 0; k--) begin
      if (match_vec[k]) begin
        search_k = OFF_W'(k);
      end
    end
  end

  // d tracks where the next frame boundary will sit once enough new bits have arrived.
  always_comb begin
    d_sum     = d + SER_D;
    frame_due = (d_sum >= SAMPLE_D);
    d_red     = d_sum - SAMPLE_D;
    d_next    = frame_due ? d_red : d_sum;
    pred_k    = d_red[OFF_W-1:0];
    pred_ok   = match_vec[pred_k];
  end

  always_comb begin
    pred_data = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      pred_data[c*SAMPLE_W +: SAMPLE_W] = data_sr[c][pred_k +: SAMPLE_W];
    end
  end

  always_ff @(posedge dco_div4 or negedge rstn) begin
    if (!rstn) begin
      state          <= ST_SEARCH;
      fco_sr         <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        data_sr[c] <= '0;
      end
      d              <= '0;
      good           <= '0;
      bad            <= '0;
      data_out       <= '0;
      data_valid_out <= 1'b0;
      locked         <= 1'b0;
      offset         <= '0;
      err_cnt        <= '0;
    end else begin
      fco_sr <= {fco_sr[SR_W-SER_W-1:0], fco_word};
      for (int c = 0; c < NUM_CH; c++) begin
        data_sr[c] <= {data_sr[c][SR_W-SER_W-1:0], data_in[c*SER_W +: SER_W]};
      end
      data_valid_out <= 1'b0;

      if (realign) begin
        state   <= ST_SEARCH;
        locked  <= 1'b0;
        err_cnt <= '0;
        d       <= '0;
        good    <= '0;
        bad     <= '0;
      end else begin
        case (state)
          ST_SEARCH: begin
            if (search_hit) begin
              d     <= {{(D_W-OFF_W){1'b0}}, search_k};
              good  <= '0;
              state <= ST_VERIFY;
            end
          end

          ST_VERIFY: begin
            d <= d_next;
            if (frame_due) begin
              if (pred_ok) begin
                if (good == GOOD_LAST) begin
                  state  <= ST_LOCKED;
                  locked <= 1'b1;
                  bad    <= '0;
                end else begin
                  good <= good + 1'b1;
                end
              end else begin
                state <= ST_SEARCH;
              end
            end
          end

          ST_LOCKED: begin
            d <= d_next;
            if (frame_due) begin
              if (pred_ok) begin
                data_out       <= pred_data;
                offset         <= pred_k;
                data_valid_out <= 1'b1;
                bad            <= '0;
              end else begin
                if (err_cnt != 16'hFFFF) begin
                  err_cnt <= err_cnt + 16'd1;
                end
                if (bad == BAD_LAST) begin
                  state  <= ST_SEARCH;
                  locked <= 1'b0;
                  bad    <= '0;
                end else begin
                  bad <= bad + 1'b1;
                end
              end
            end
          end

          default: begin
            state  <= ST_SEARCH;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_adc_frame_gearbox.sv
// tb/tb_adc_frame_gearbox.sv - scoreboard bench for adc_frame_gearbox
module tb_adc_frame_gearbox;

  localparam int NUM_CH   = 4;
  localparam int SER_W    = 8;
  localparam int SAMPLE_W = 12;

  logic                        dco_div4;
  logic                        rstn;
  logic [SER_W-1:0]            fco_word;
  logic [NUM_CH*SER_W-1:0]     data_in;
  logic                        realign;
  logic [NUM_CH*SAMPLE_W-1:0]  data_out;
  logic                        data_valid_out;
  logic                        locked;
  logic [$clog2(SER_W)-1:0]    offset;
  logic [15:0]                 err_cnt;

  adc_frame_gearbox #(
    .NUM_CH(NUM_CH), .SER_W(SER_W), .SAMPLE_W(SAMPLE_W), .LOCK_COUNT(4), .ERR_LIMIT(2)
  ) dut (
    .dco_div4(dco_div4), .rstn(rstn), .fco_word(fco_word), .data_in(data_in),
    .realign(realign), .data_out(data_out), .data_valid_out(data_valid_out),
    .locked(locked), .offset(offset), .err_cnt(err_cnt)
  );

  initial dco_div4 = 1'b0;
  always #5 dco_div4 = ~dco_div4;

  typedef struct {
    logic [NUM_CH*SAMPLE_W-1:0] data;
    int                         p;
  } frame_t;

  frame_t                sb_q[$];
  bit                    fco_q[$];
  logic [NUM_CH-1:0]     dat_q[$];
  bit                    end_q[$];

  int tests = 0;
  int fails = 0;
  int bitpos = 0;
  int n_gen = 0;
  int corrupt_frames = 0;
  bit slip_pending = 0;
  int frames_done = 0;
  bit word_has_end = 0;
  int valids = 0;
  int dropped = 0;
  logic [NUM_CH*SAMPLE_W-1:0] last_data = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Offset at which a frame whose MSB is stream bit p sits when its last bit has just arrived.
  function automatic int exp_k(input int p);
    int k;
    k = (-(p + 4)) % SER_W;
    if (k < 0) k += SER_W;
    return k;
  endfunction

  task automatic gen_sample();
    frame_t                e;
    logic [SAMPLE_W-1:0]   s [NUM_CH];
    logic [NUM_CH-1:0]     db;
    if (slip_pending) begin
      fco_q.push_back(1'b0);
      dat_q.push_back('0);
      end_q.push_back(1'b0);
      bitpos++;
      slip_pending = 0;
    end
    e.data = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      s[c] = SAMPLE_W'(c * 256 + n_gen);
      e.data[c*SAMPLE_W +: SAMPLE_W] = s[c];
    end
    e.p = bitpos;
    for (int i = SAMPLE_W - 1; i >= 0; i--) begin
      for (int c = 0; c < NUM_CH; c++) db[c] = s[c][i];
      fco_q.push_back((corrupt_frames > 0) ? 1'b0 : (i >= SAMPLE_W/2));
      dat_q.push_back(db);
      end_q.push_back(i == 0);
    end
    sb_q.push_back(e);
    bitpos += SAMPLE_W;
    n_gen++;
    if (corrupt_frames > 0) corrupt_frames--;
  endtask

  task automatic drive_word();
    logic [NUM_CH-1:0] db;
    word_has_end = 0;
    while (fco_q.size() < SER_W) gen_sample();
    for (int b = SER_W - 1; b >= 0; b--) begin
      fco_word[b] = fco_q.pop_front();
      db = dat_q.pop_front();
      for (int c = 0; c < NUM_CH; c++) data_in[c*SER_W + b] = db[c];
      if (end_q.pop_front()) begin
        frames_done++;
        word_has_end = 1;
      end
    end
  endtask

  task automatic monitor();
    frame_t e;
    if (data_valid_out) begin
      valids++;
      while (sb_q.size() > 0 && sb_q[0].data[SAMPLE_W-1:0] != data_out[SAMPLE_W-1:0]) begin
        void'(sb_q.pop_front());
        dropped++;
      end
      if (sb_q.size() == 0) begin
        check("sb_match", 64'(data_out), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        e = sb_q.pop_front();
        check("data", 64'(data_out), 64'(e.data));
        check("offset", 64'(offset), 64'(exp_k(e.p)));
        last_data = e.data;
      end
    end else begin
      check("hold", 64'(data_out), 64'(last_data));
    end
  endtask

  task automatic cycle();
    @(negedge dco_div4);
    monitor();
    drive_word();
  endtask

  task automatic wait_lock(input int budget);
    for (int i = 0; i < budget && !locked; i++) cycle();
    check("lock_reached", 64'(locked), 64'd1);
  endtask

  task automatic wait_unlock(input int budget);
    for (int i = 0; i < budget && locked; i++) cycle();
    check("lock_lost", 64'(locked), 64'd0);
  endtask

  task automatic check_reset_outputs();
    check("rst_data", 64'(data_out), 64'd0);
    check("rst_valid", 64'(data_valid_out), 64'd0);
    check("rst_locked", 64'(locked), 64'd0);
    check("rst_offset", 64'(offset), 64'd0);
    check("rst_err", 64'(err_cnt), 64'd0);
  endtask

  int v0;
  int d0;

  initial begin
    rstn     = 1'b0;
    realign  = 1'b0;
    fco_word = '0;
    data_in  = '0;
    // One lead bit puts the first frame at offset 3.
    fco_q.push_back(1'b0);
    dat_q.push_back('0);
    end_q.push_back(1'b0);
    bitpos = 1;

    repeat (3) @(negedge dco_div4);
    check_reset_outputs();
    rstn = 1'b1;
    frames_done = 0;
    drive_word();
    wait_lock(80);
    check("lock_frames_first", 64'(frames_done >= 5), 64'd1);
    repeat (10) cycle();

    // Asynchronous reset in the middle of the stream.
    @(posedge dco_div4);
    #2;
    rstn = 1'b0;
    last_data = '0;
    #1;
    check_reset_outputs();
    repeat (2) cycle();
    rstn = 1'b1;
    frames_done = 0;
    wait_lock(80);
    check("lock_frames_reset", 64'(frames_done >= 5), 64'd1);

    // Steady-state cadence and ordering.
    repeat (6) cycle();
    v0 = valids;
    d0 = dropped;
    repeat (30) cycle();
    check("cadence", 64'(valids - v0), 64'd20);
    check("no_drops", 64'(dropped - d0), 64'd0);
    check("err_clean", 64'(err_cnt), 64'd0);

    // Single corrupted FCO frame.
    d0 = dropped;
    corrupt_frames = 1;
    repeat (30) cycle();
    check("err_single", 64'(err_cnt), 64'd1);
    check("locked_single", 64'(locked), 64'd1);
    check("drop_single", 64'(dropped - d0), 64'd1);

    // Two consecutive corrupted frames drop lock.
    corrupt_frames = 2;
    wait_unlock(40);
    check("err_double", 64'(err_cnt), 64'd3);
    wait_lock(80);
    repeat (10) cycle();

    // One-bit slip on all lanes.
    slip_pending = 1;
    wait_unlock(40);
    check("err_slip", 64'(err_cnt), 64'd5);
    wait_lock(80);
    v0 = valids;
    repeat (20) cycle();
    check("valids_after_slip", 64'(valids - v0 >= 12), 64'd1);

    // realign coincident with an expected frame.
    word_has_end = 0;
    for (int i = 0; i < 20 && !word_has_end; i++) cycle();
    check("realign_sync", 64'(word_has_end), 64'd1);
    @(negedge dco_div4);
    monitor();
    realign = 1'b1;
    drive_word();
    @(negedge dco_div4);
    check("realign_valid", 64'(data_valid_out), 64'd0);
    check("realign_locked", 64'(locked), 64'd0);
    check("realign_err", 64'(err_cnt), 64'd0);
    realign = 1'b0;
    monitor();
    drive_word();
    wait_lock(80);
    v0 = valids;
    repeat (15) cycle();
    check("valids_after_realign", 64'(valids - v0 >= 9), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
